// File: rtl/alu16_sequencer.sv
// alu16_sequencer: runs 16-bit ADD16/INC16/DEC16/ADDSP as two byte passes on the shared 8-bit ALU.
//   clock, reset_n          : clock (rising edge), asynchronous active-low reset
//   start, op, a_in, b_in   : request and operands, sampled only in IDLE or DONE
//   flags_in                : CPU flags ZNHC at request time
//   busy, done              : busy in LOW/HIGH, one-cycle done pulse when result is valid
//   result, flags_out       : 16-bit result and final flags, held until the next done
//   alu_own                 : this block owns the ALU inputs (LOW/HIGH)
//   alu_op..alu_size        : registered drive of the shared 8-bit ALU
//   alu_data_out/flags_out  : ALU result, sampled at the end of LOW and HIGH
module alu16_sequencer #(
    parameter int F_Z = 3,
    parameter int F_N = 2,
    parameter int F_H = 1,
    parameter int F_C = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [3:0]  flags_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  flags_out,
    output logic        alu_own,
    output logic [4:0]  alu_op,
    output logic [7:0]  alu_data0,
    output logic [7:0]  alu_data1,
    output logic [3:0]  alu_flags,
    output logic        alu_size,
    input  logic [7:0]  alu_data_out,
    input  logic [3:0]  alu_flags_out
);
    // ALU encodings shared with the CPU control unit
    localparam logic [4:0] ALU_PASS0   = 5'd0;
    localparam logic [4:0] ALU_ADD     = 5'd1;
    localparam logic [4:0] ALU_ADC     = 5'd2;
    localparam logic       ALU_SIZE_8  = 1'b0;
    localparam logic       ALU_SIZE_16 = 1'b1;
    localparam logic [1:0] OP_ADD16 = 2'd0;
    localparam logic [1:0] OP_INC16 = 2'd1;
    localparam logic [1:0] OP_DEC16 = 2'd2;
    localparam logic [1:0] OP_ADDSP = 2'd3;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0]  fl_q, fl_d, flags_out_q, flags_out_d, alu_flags_q, alu_flags_d;
    logic [7:0]  lo_q, lo_d, data0_q, data0_d, data1_q, data1_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic        cy_q, cy_d, hlo_q, hlo_d, busy_q, busy_d, done_q, done_d, alu_size_q, alu_size_d;
    logic        accept;
    // Z and N of the ALU flag result are never consumed
    logic        unused_alu_flags;

    assign unused_alu_flags = ^alu_flags_out;

    always_comb begin
        accept      = start && (state_q == IDLE || state_q == DONE);
        state_d     = (state_q == LOW) ? HIGH : (state_q == HIGH) ? DONE : accept ? LOW : IDLE;
        op_d        = accept ? op : op_q;
        a_d         = accept ? a_in : a_q;
        b_d         = accept ? b_in : b_q;
        fl_d        = accept ? flags_in : fl_q;
        lo_d        = (state_q == LOW) ? alu_data_out : lo_q;
        cy_d        = (state_q == LOW) ? alu_flags_out[F_C] : cy_q;
        hlo_d       = (state_q == LOW) ? alu_flags_out[F_H] : hlo_q;
        busy_d      = (state_d == LOW) || (state_d == HIGH);
        done_d      = state_d == DONE;
        alu_op_d    = ALU_PASS0;
        data0_d     = 8'h00;
        data1_d     = 8'h00;
        alu_flags_d = 4'h0;
        alu_size_d  = ALU_SIZE_8;
        // Drive is registered, so it is computed for the state being entered
        if (state_d == LOW) begin
            alu_op_d    = ALU_ADD;
            data1_d     = a_d[7:0];
            alu_flags_d = fl_d;
            data0_d     = (op_d == OP_INC16) ? 8'h01 : (op_d == OP_DEC16) ? 8'hFF : b_d[7:0];
            alu_size_d  = (op_d == OP_ADDSP) ? ALU_SIZE_8 : ALU_SIZE_16;
        end else if (state_d == HIGH) begin
            alu_op_d         = ALU_ADC;
            data1_d          = a_q[15:8];
            alu_size_d       = ALU_SIZE_16;
            alu_flags_d      = fl_q;
            alu_flags_d[F_C] = cy_d;
            data0_d          = (op_q == OP_ADD16) ? b_q[15:8] : (op_q == OP_INC16) ? 8'h00 :
                               (op_q == OP_DEC16) ? 8'hFF : {8{b_q[7]}};
        end
        result_d    = result_q;
        flags_out_d = flags_out_q;
        if (state_q == HIGH) begin
            result_d    = {alu_data_out, lo_q};
            flags_out_d = fl_q;
            if (op_q == OP_ADD16) begin
                flags_out_d[F_N] = 1'b0;
                flags_out_d[F_H] = alu_flags_out[F_H];
                flags_out_d[F_C] = alu_flags_out[F_C];
            end else if (op_q == OP_ADDSP) begin
                // SP+e flags come from the low-byte add only
                flags_out_d[F_Z] = 1'b0;
                flags_out_d[F_N] = 1'b0;
                flags_out_d[F_H] = hlo_q;
                flags_out_d[F_C] = cy_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= 2'd0;
            a_q         <= 16'h0;
            b_q         <= 16'h0;
            fl_q        <= 4'h0;
            lo_q        <= 8'h0;
            cy_q        <= 1'b0;
            hlo_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 16'h0;
            flags_out_q <= 4'h0;
            alu_op_q    <= ALU_PASS0;
            data0_q     <= 8'h0;
            data1_q     <= 8'h0;
            alu_flags_q <= 4'h0;
            alu_size_q  <= ALU_SIZE_8;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fl_q        <= fl_d;
            lo_q        <= lo_d;
            cy_q        <= cy_d;
            hlo_q       <= hlo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            flags_out_q <= flags_out_d;
            alu_op_q    <= alu_op_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            alu_flags_q <= alu_flags_d;
            alu_size_q  <= alu_size_d;
        end
    end

    assign busy      = busy_q;
    assign alu_own   = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign flags_out = flags_out_q;
    assign alu_op    = alu_op_q;
    assign alu_data0 = data0_q;
    assign alu_data1 = data1_q;
    assign alu_flags = alu_flags_q;
    assign alu_size  = alu_size_q;
endmodule

// File: tb/tb_alu16_sequencer.sv
// tb_alu16_sequencer: random and directed checks of alu16_sequencer against a 16-bit arithmetic model.
module tb_alu16_sequencer;
    localparam logic [4:0] ALU_PASS0 = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_ADC   = 5'd2;

    logic        clock, reset_n, start;
    logic [1:0]  op;
    logic [15:0] a_in, b_in, result;
    logic [3:0]  flags_in, flags_out, alu_flags, alu_flags_out;
    logic        busy, done, alu_own, alu_size;
    logic [4:0]  alu_op;
    logic [7:0]  alu_data0, alu_data1, alu_data_out;
    int          n_vec, n_err;
    logic [15:0] prev_res;
    logic [3:0]  prev_fl;

    alu16_sequencer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .flags_in(flags_in), .busy(busy), .done(done), .result(result), .flags_out(flags_out),
        .alu_own(alu_own), .alu_op(alu_op), .alu_data0(alu_data0), .alu_data1(alu_data1),
        .alu_flags(alu_flags), .alu_size(alu_size), .alu_data_out(alu_data_out),
        .alu_flags_out(alu_flags_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural 8-bit ALU (ZNHC flags)
    always_comb begin
        logic [8:0] s;
        logic [4:0] h;
        logic       cin;
        cin           = (alu_op == ALU_ADC) ? alu_flags[0] : 1'b0;
        s             = {1'b0, alu_data0} + {1'b0, alu_data1} + {8'h0, cin};
        h             = {1'b0, alu_data0[3:0]} + {1'b0, alu_data1[3:0]} + {4'h0, cin};
        alu_data_out  = 8'h00;
        alu_flags_out = 4'h0;
        if (alu_op == ALU_ADD || alu_op == ALU_ADC) begin
            alu_data_out  = s[7:0];
            alu_flags_out = {s[7:0] == 8'h00, 1'b0, h[4], s[8]};
        end else if (alu_op == ALU_PASS0) begin
            alu_data_out  = alu_data0;
            alu_flags_out = alu_flags;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // 16-bit reference: plain arithmetic on whole words
    function automatic void model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] f, output logic [15:0] r, output logic [3:0] fo);
        int sa, se;
        sa = int'(a);
        se = int'({{8{b[7]}}, b[7:0]});
        case (o)
            2'd0: begin
                r  = a + b;
                fo = {f[3], 1'b0, ((sa & 'hFFF) + (int'(b) & 'hFFF)) > 'hFFF, (sa + int'(b)) > 'hFFFF};
            end
            2'd1: begin r = a + 16'd1; fo = f; end
            2'd2: begin r = a - 16'd1; fo = f; end
            default: begin
                r  = a + 16'(se);
                fo = {2'b00, ((sa & 'hF) + (se & 'hF)) > 'hF, ((sa & 'hFF) + (se & 'hFF)) > 'hFF};
            end
        endcase
    endfunction

    task automatic scramble();
        op       = 2'($urandom);
        a_in     = 16'($urandom);
        b_in     = 16'($urandom);
        flags_in = 4'($urandom);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f);
        logic [15:0] er;
        logic [3:0]  ef;
        model(o, a, b, f, er, ef);
        @(negedge clock);
        start = 1'b1; op = o; a_in = a; b_in = b; flags_in = f;
        @(negedge clock);
        scramble();
        start = 1'($urandom);
        chk("low_busy", busy, 1);
        chk("low_own", alu_own, 1);
        chk("low_done", done, 0);
        chk("low_aluop", alu_op, ALU_ADD);
        chk("low_held", {flags_out, result}, {prev_fl, prev_res});
        @(negedge clock);
        scramble();
        start = 1'b0;
        chk("high_busy", busy, 1);
        chk("high_aluop", alu_op, ALU_ADC);
        chk("high_done", done, 0);
        chk("high_held", {flags_out, result}, {prev_fl, prev_res});
        @(negedge clock);
        chk("done", done, 1);
        chk("done_own", {busy, alu_own}, 2'b00);
        chk("result", result, er);
        chk("flags", flags_out, ef);
        prev_res = er;
        prev_fl  = ef;
    endtask

    initial begin
        logic [15:0] va[3], vb[3], er;
        logic [3:0]  vf[3], ef;
        int          n_done;
        n_vec = 0; n_err = 0; prev_res = 16'h0; prev_fl = 4'h0;
        reset_n = 1'b0; start = 1'b0; op = 2'd0; a_in = 16'h0; b_in = 16'h0; flags_in = 4'h0;
        repeat (3) @(negedge clock);
        chk("rst_status", {busy, done, alu_own}, 3'b000);
        chk("rst_result", {flags_out, result}, 20'h0);
        chk("rst_drive", {alu_op, alu_data0, alu_data1, alu_flags, alu_size}, {ALU_PASS0, 8'h0, 8'h0, 4'h0, 1'b0});
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_busy", {busy, done}, 2'b00);

        run_op(2'd0, 16'h0FFF, 16'h0001, 4'b1000);
        run_op(2'd0, 16'hFFFF, 16'h0001, 4'b0000);
        run_op(2'd1, 16'h00FF, 16'h1234, 4'b0101);
        run_op(2'd2, 16'h0000, 16'hABCD, 4'b1110);
        run_op(2'd3, 16'hFFF8, 16'h0008, 4'b1111);
        run_op(2'd3, 16'h0005, 16'h00FE, 4'b0000);
        run_op(2'd3, 16'h1000, 16'h0080, 4'b1100);

        // start held high: only IDLE/DONE samples are accepted
        for (int k = 0; k < 3; k++) begin
            va[k] = 16'($urandom); vb[k] = 16'($urandom); vf[k] = 4'($urandom);
        end
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i > 0) begin
                chk("b2b_done", done, ((i - 1) % 3) == 2);
                chk("b2b_busy", busy, ((i - 1) % 3) != 2);
                chk("b2b_own", alu_own, busy);
                if (done) begin
                    model(2'(n_done), va[n_done], vb[n_done], vf[n_done], er, ef);
                    chk("b2b_result", {flags_out, result}, {ef, er});
                    prev_res = er; prev_fl = ef;
                    n_done++;
                end
            end
            if (i < 9) begin
                start = 1'b1;
                if (i % 3 == 0) begin
                    op = 2'(i / 3); a_in = va[i / 3]; b_in = vb[i / 3]; flags_in = vf[i / 3];
                end else scramble();
            end else start = 1'b0;
        end
        chk("b2b_count", n_done, 3);

        // reset during HIGH aborts the operation
        @(negedge clock);
        start = 1'b1; op = 2'd0; a_in = 16'h1234; b_in = 16'h4321; flags_in = 4'h0;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("arst_status", {busy, alu_own, done}, 3'b000);
        chk("arst_result", {flags_out, result}, 20'h0);
        prev_res = 16'h0; prev_fl = 4'h0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("post_rst_idle", {busy, done}, 2'b00);
        end
        run_op(2'd0, 16'h1234, 16'h4321, 4'b0000);

        for (int i = 0; i < 150; i++)
            run_op(2'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu16_sequencer.md
Name: alu16_sequencer

Overview:
Multi-cycle controller that runs 16-bit arithmetic on the existing 8-bit combinational ALU. It executes each operation as two byte passes: low byte, then high byte, with the low-byte carry fed back as the high-byte carry-in. While it holds the ALU, it asserts an ownership signal so the CPU-side ALU input mux selects this block's operands. It serves ADD HL,rr / INC rr / DEC rr / ADD SP,e from the CPU control unit.

Parameters:
F_Z, 3, bit index of Z in 4-bit flag vectors (ZNHC)
F_N, 2, bit index of N
F_H, 1, bit index of H
F_C, 0, bit index of C

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
op  in  2  0=ADD16, 1=INC16, 2=DEC16, 3=ADDSP
a_in  in  16  first operand (HL, rr, or SP)
b_in  in  16  second operand (rr for ADD16; b_in[7:0]=signed e for ADDSP; ignored otherwise)
flags_in  in  4  current CPU flags ZNHC
busy  out  1  high in LOW and HIGH states
done  out  1  one-cycle pulse, result valid
result  out  16  16-bit result, held until next done
flags_out  out  4  final flags, held until next done
alu_own  out  1  high in LOW/HIGH; CPU mux gives ALU inputs to this block
alu_op  out  5  ALU opcode (`ALU_* from cpu.vh)
alu_data0  out  8  ALU operand 0
alu_data1  out  8  ALU operand 1
alu_flags  out  4  ALU flags_in
alu_size  out  1  `ALU_SIZE_8 / `ALU_SIZE_16
alu_data_out  in  8  ALU result
alu_flags_out  in  4  ALU flags result

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0, done=0, alu_own=0, result=0, flags_out=0, internal latches=0; ALU drive = `ALU_PASS0, data0=data1=0, alu_flags=0, alu_size=`ALU_SIZE_8. Reset mid-operation aborts it; no done issued.
- FSM: IDLE -> LOW on start. LOW -> HIGH unconditionally. HIGH -> DONE unconditionally. DONE -> LOW if start, else IDLE. start in LOW/HIGH is ignored (not queued).
- On accepted start: latch op, a_in, b_in, flags_in. The block uses only latched values afterwards.
- Latency: start sampled at edge N; LOW during cycle N+1; HIGH during N+2; DONE (done=1) during N+3. Back-to-back throughput is one op per 3 cycles.
- LOW drive: alu_data1=a[7:0], alu_op=`ALU_ADD, alu_flags=latched flags.
  - data0: ADD16 -> b[7:0]; INC16 -> 8'h01; DEC16 -> 8'hFF; ADDSP -> b[7:0].
  - alu_size: `ALU_SIZE_8 for ADDSP, else `ALU_SIZE_16.
  - End of LOW: capture lo=alu_data_out, cy=alu_flags_out[F_C], hlo=alu_flags_out[F_H].
- HIGH drive: alu_op=`ALU_ADC, alu_data1=a[15:8], alu_size=`ALU_SIZE_16, alu_flags = latched flags with bit F_C replaced by cy.
  - data0: ADD16 -> b[15:8]; INC16 -> 8'h00; DEC16 -> 8'hFF; ADDSP -> {8{b[7]}}.
  - End of HIGH: result={alu_data_out, lo}; flags_out updated per op.
- DEC16 is implemented as +0xFFFF (mod 2^16). ALU_SUB/SBC are not used.
- Final flags (written at end of HIGH):
  - ADD16: Z=latched Z, N=0, H=alu_flags_out[F_H] (carry out of bit 11), C=alu_flags_out[F_C] (carry out of bit 15).
  - INC16/DEC16: flags_out = latched flags unchanged.
  - ADDSP: Z=0, N=0, H=hlo, C=cy (both from low-byte add).
- result/flags_out change only at the HIGH->DONE edge.

Test Plan:
1. ADD16 a=0x0FFF b=0x0001 flags_in=4'b1000 -> done 3 cycles after start, result=0x1000, flags_out=4'b1010.
2. ADD16 a=0xFFFF b=0x0001 flags_in=4'b0000 -> result=0x0000, flags_out=4'b0011 (Z not set).
3. INC16 a=0x00FF flags_in=4'b0101 -> result=0x0100, flags_out=4'b0101. DEC16 a=0x0000 flags_in=4'b1110 -> result=0xFFFF, flags_out=4'b1110.
4. ADDSP a=0xFFF8 b=0x0008 -> result=0x0000, flags_out=4'b0011. ADDSP a=0x0005 b=0x00FE -> result=0x0003, flags_out=4'b0011. ADDSP a=0x1000 b=0x0080 -> result=0x0F80, flags_out=4'b0000.
5. start held high 9 cycles with ops ADD16, INC16, DEC16 -> exactly 3 done pulses 3 cycles apart. alu_own=busy throughout. start pulses during LOW/HIGH produce no extra done.
6. reset_n driven low during HIGH -> same cycle busy=0, alu_own=0, done=0, result=0. After release, idle until next start; the next op then completes normally.
